// File: rtl/hazard_ctrl_gen2.sv
// Hazard controller for the 5-stage core: stage enables/flushes, PC select,
// configurable load-use bubbles, dmem wait watchdog and stall/flush counters.
module hazard_ctrl_gen2 #(
    parameter int RW         = 5,
    parameter int LINK       = 31,
    parameter int LU_BUBBLES = 1,
    parameter int MEM_TO     = 64,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             me_ldst,
    input  logic             ex_ren,
    input  logic [RW-1:0]    ex_rdst,
    input  logic [RW-1:0]    rs,
    input  logic [RW-1:0]    rt,
    input  logic [2:0]       pcsrc,
    input  logic             equal,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic             pcen,
    output logic             deen,
    output logic             exen,
    output logic             meen,
    output logic             wben,
    output logic             deflush,
    output logic             exflush,
    output logic             meflush,
    output logic [1:0]       pcsel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_LU_STALL = 2'd1, ST_HALT = 2'd2} state_t;

    localparam int               WCW      = (MEM_TO > 0) ? $clog2(MEM_TO + 1) : 1;
    localparam logic [WCW-1:0]   TO_LAST  = WCW'((MEM_TO > 0) ? MEM_TO - 1 : 0);
    localparam logic [1:0]       BUB_LOAD = 2'((LU_BUBBLES > 1) ? LU_BUBBLES - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_r, state_n;
    logic [2:0]       br_r;
    logic [1:0]       bub_cnt_r, bub_cnt_n;
    logic [WCW-1:0]   wait_cnt_r;
    logic             mem_err_r;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    logic lu_hazard_s, lu_rule_s, taken_s, mem_wait_s, timeout_s, recover_s;

    // Hazard classification from decode/execute/memory stage state.
    always_comb begin
        lu_hazard_s = ex_ren && (ex_rdst != {RW{1'b0}}) &&
                      ((rs == ex_rdst) || (rt == ex_rdst) ||
                       ((pcsrc == 3'd1) && (ex_rdst == RW'(LINK))));
        lu_rule_s   = (state_r == ST_LU_STALL) || lu_hazard_s;
        taken_s     = ((br_r == 3'd3) && equal) || ((br_r == 3'd4) && !equal);
        mem_wait_s  = me_ldst && !dhit;
        timeout_s   = (MEM_TO > 0) && mem_wait_s && (wait_cnt_r == TO_LAST);
        recover_s   = (state_r == ST_HALT) && err_clr && !timeout_s;
    end

    // Prioritised enable/flush/PC-select generation.
    always_comb begin
        pcen = 1'b0; deen = 1'b0; exen = 1'b0; meen = 1'b0; wben = 1'b0;
        deflush = 1'b0; exflush = 1'b0; meflush = 1'b0;
        pcsel = 2'd0;
        if (state_r == ST_HALT) begin
            pcen = 1'b0;
        end else if (me_ldst) begin
            if (dhit && ihit) begin
                pcen = 1'b1; deen = 1'b1; exen = 1'b1; meen = 1'b1; wben = 1'b1;
            end else if (dhit) begin
                wben = 1'b1; meflush = 1'b1;
            end else begin
                wben = 1'b0;
            end
        end else if (lu_rule_s) begin
            meen = ihit; wben = ihit; exflush = ihit;
        end else if (taken_s) begin
            pcsel = 2'd3;
            pcen = ihit; meen = ihit; wben = ihit; exflush = ihit; deflush = ihit;
        end else if ((pcsrc == 3'd2) || (pcsrc == 3'd1)) begin
            pcsel = (pcsrc == 3'd2) ? 2'd2 : 2'd1;
            pcen = ihit; exen = ihit; meen = ihit; wben = ihit; deflush = ihit;
        end else begin
            pcen = ihit; deen = ihit; exen = ihit; meen = ihit; wben = ihit;
        end
    end

    // Next state and bubble counter; memory-stage stalls freeze the bubble count.
    always_comb begin
        state_n   = state_r;
        bub_cnt_n = bub_cnt_r;
        if (timeout_s) begin
            state_n = ST_HALT;
        end else if (state_r == ST_HALT) begin
            if (err_clr) begin
                state_n   = ST_RUN;
                bub_cnt_n = 2'd0;
            end else begin
                state_n = ST_HALT;
            end
        end else if (me_ldst) begin
            state_n = state_r;
        end else if (lu_rule_s && ihit) begin
            case (state_r)
                ST_RUN: begin
                    if (LU_BUBBLES > 1) begin
                        state_n   = ST_LU_STALL;
                        bub_cnt_n = BUB_LOAD;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
                ST_LU_STALL: begin
                    if (bub_cnt_r == 2'd0) begin
                        state_n = ST_RUN;
                    end else begin
                        bub_cnt_n = bub_cnt_r - 2'd1;
                    end
                end
                default: state_n = ST_RUN;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Control state, execute-stage branch code, watchdog and sticky error.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r    <= ST_RUN;
            bub_cnt_r  <= 2'd0;
            br_r       <= 3'd0;
            wait_cnt_r <= {WCW{1'b0}};
            mem_err_r  <= 1'b0;
        end else begin
            state_r   <= state_n;
            bub_cnt_r <= bub_cnt_n;
            if (recover_s || exflush) begin
                br_r <= 3'd0;
            end else if (exen) begin
                br_r <= pcsrc;
            end
            if (recover_s || !mem_wait_s) begin
                wait_cnt_r <= {WCW{1'b0}};
            end else begin
                wait_cnt_r <= wait_cnt_r + WCW'(1);
            end
            if (timeout_s) begin
                mem_err_r <= 1'b1;
            end else if (recover_s) begin
                mem_err_r <= 1'b0;
            end
        end
    end

    // Saturating performance counters; HALT cycles are not stalls.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!pcen && (state_r != ST_HALT) && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if ((deflush || exflush) && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign mem_err      = mem_err_r;
    assign stall_cycles = stall_cnt_r;
    assign flush_count  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl_gen2.sv
// Directed bench for hazard_ctrl_gen2 (LU_BUBBLES=2, MEM_TO=4) with
// hand-computed expectations for enables, flushes, PC select and counters.
module tb_hazard_ctrl_gen2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, me_ldst, ex_ren, equal, err_clr, cnt_clr;
    logic [4:0]  ex_rdst, rs, rt;
    logic [2:0]  pcsrc;
    logic        pcen, deen, exen, meen, wben, deflush, exflush, meflush, mem_err;
    logic [1:0]  pcsel;
    logic [31:0] stall_cycles, flush_count;
    logic [4:0]  en_v;
    logic [2:0]  fl_v;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl_gen2 #(.RW(5), .LINK(31), .LU_BUBBLES(2), .MEM_TO(4), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .me_ldst(me_ldst),
        .ex_ren(ex_ren), .ex_rdst(ex_rdst), .rs(rs), .rt(rt), .pcsrc(pcsrc),
        .equal(equal), .err_clr(err_clr), .cnt_clr(cnt_clr),
        .pcen(pcen), .deen(deen), .exen(exen), .meen(meen), .wben(wben),
        .deflush(deflush), .exflush(exflush), .meflush(meflush), .pcsel(pcsel),
        .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

    assign en_v = {pcen, deen, exen, meen, wben};
    assign fl_v = {deflush, exflush, meflush};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] en, input logic [2:0] fl,
                           input logic [1:0] sel);
        #1;
        check_val({tag, "_en"}, {27'd0, en_v}, {27'd0, en});
        check_val({tag, "_fl"}, {29'd0, fl_v}, {29'd0, fl});
        check_val({tag, "_sel"}, {30'd0, pcsel}, {30'd0, sel});
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; me_ldst = 1'b0; ex_ren = 1'b0;
        equal = 1'b0; err_clr = 1'b0; cnt_clr = 1'b0;
        ex_rdst = 5'd0; rs = 5'd0; rt = 5'd0; pcsrc = 3'd0;
        cyc();
        chk_ctl("reset", 5'b00000, 3'b000, 2'd0);
        check_val("reset_err", {31'd0, mem_err}, 32'd0);
        check_val("reset_stall", stall_cycles, 32'd0);
        check_val("reset_flush", flush_count, 32'd0);

        nRST = 1'b1; ihit = 1'b1;
        chk_ctl("run", 5'b11111, 3'b000, 2'd0);
        cyc();

        // load-use, two bubbles
        ex_ren = 1'b1; ex_rdst = 5'd5; rs = 5'd5;
        chk_ctl("lu1", 5'b00011, 3'b010, 2'd0);
        cyc();
        ex_ren = 1'b0;
        chk_ctl("lu2", 5'b00011, 3'b010, 2'd0);
        cyc();
        rs = 5'd0;
        chk_ctl("lu_done", 5'b11111, 3'b000, 2'd0);
        check_val("lu_stall_cnt", stall_cycles, 32'd2);
        check_val("lu_flush_cnt", flush_count, 32'd2);
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        check_val("clr_stall", stall_cycles, 32'd0);
        check_val("clr_flush", flush_count, 32'd0);

        // writing r0 never hazards
        ex_ren = 1'b1; ex_rdst = 5'd0;
        chk_ctl("r0", 5'b11111, 3'b000, 2'd0);
        cyc();
        ex_ren = 1'b0;

        // beq taken
        pcsrc = 3'd3;
        chk_ctl("beq_dec", 5'b11111, 3'b000, 2'd0);
        cyc();
        pcsrc = 3'd0; equal = 1'b1;
        chk_ctl("beq_taken", 5'b10011, 3'b110, 2'd3);
        cyc();
        check_val("beq_flush_cnt", flush_count, 32'd1);
        chk_ctl("beq_after", 5'b11111, 3'b000, 2'd0);
        cyc();

        // bne with equal=1 is not taken
        pcsrc = 3'd4;
        cyc();
        pcsrc = 3'd0;
        chk_ctl("bne_nt", 5'b11111, 3'b000, 2'd0);
        cyc();
        equal = 1'b0;

        // jump
        pcsrc = 3'd2;
        chk_ctl("jump", 5'b10111, 3'b100, 2'd2);
        cyc();
        pcsrc = 3'd0;
        chk_ctl("jump_after", 5'b11111, 3'b000, 2'd0);
        cyc();

        // jr on link register written by a load
        pcsrc = 3'd1; ex_ren = 1'b1; ex_rdst = 5'd31; rs = 5'd1; rt = 5'd2;
        chk_ctl("jr_lu1", 5'b00011, 3'b010, 2'd0);
        cyc();
        ex_ren = 1'b0;
        chk_ctl("jr_lu2", 5'b00011, 3'b010, 2'd0);
        cyc();
        chk_ctl("jr", 5'b10111, 3'b100, 2'd1);
        cyc();
        pcsrc = 3'd0; rs = 5'd0; rt = 5'd0; ex_rdst = 5'd0;

        // memory stage done, fetch pending
        me_ldst = 1'b1; dhit = 1'b1; ihit = 1'b0; cnt_clr = 1'b1;
        chk_ctl("me_noi", 5'b00001, 3'b001, 2'd0);
        cyc();
        cnt_clr = 1'b0;
        check_val("cntclr_stall", stall_cycles, 32'd0);
        check_val("cntclr_flush", flush_count, 32'd0);
        ihit = 1'b1;
        chk_ctl("me_hit", 5'b11111, 3'b000, 2'd0);
        cyc();

        // watchdog timeout after 4 wait cycles
        dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_ctl("wait", 5'b00000, 3'b000, 2'd0);
            cyc();
        end
        check_val("wait_noerr", {31'd0, mem_err}, 32'd0);
        cyc();
        check_val("to_err", {31'd0, mem_err}, 32'd1);
        check_val("to_stall", stall_cycles, 32'd4);
        dhit = 1'b1;
        chk_ctl("halt", 5'b00000, 3'b000, 2'd0);
        cyc();
        check_val("halt_stall", stall_cycles, 32'd4);
        check_val("halt_err", {31'd0, mem_err}, 32'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0; me_ldst = 1'b0;
        check_val("clr_err", {31'd0, mem_err}, 32'd0);
        chk_ctl("recovered", 5'b11111, 3'b000, 2'd0);
        cyc();

        // timeout wins over a simultaneous err_clr
        me_ldst = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        err_clr = 1'b1;
        cyc();
        check_val("to_vs_clr", {31'd0, mem_err}, 32'd1);
        me_ldst = 1'b0;
        cyc();
        err_clr = 1'b0;
        check_val("clr2_err", {31'd0, mem_err}, 32'd0);

        // async reset in the middle of a load-use stall
        ex_ren = 1'b1; ex_rdst = 5'd5; rs = 5'd5;
        cyc();
        ex_ren = 1'b0; rs = 5'd0;
        chk_ctl("pre_rst", 5'b00011, 3'b010, 2'd0);
        nRST = 1'b0;
        #1;
        check_val("arst_stall", stall_cycles, 32'd0);
        chk_ctl("arst", 5'b11111, 3'b000, 2'd0);
        nRST = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
